// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default timing for the key event front end
// Ports: none (package only)
package key_pkg;
    localparam int CLK_HZ = 50_000_000;
    localparam int DEF_NUM_KEYS = 3;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 10;
    localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;
    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;
endpackage

// File: rtl/key_event_gen_if.sv
// key_event_gen_if: raw key inputs and per-key debounced level/event outputs
// Ports: key_n (raw, 0 = pressed), key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
interface key_event_gen_if #(parameter int NUM_KEYS = 3);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_pulse;
    logic [NUM_KEYS-1:0] repeat_pulse;
    modport master (output key_n, input key_level, press_pulse, release_pulse, long_pulse, repeat_pulse);
    modport slave (input key_n, output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse);
endinterface

// File: rtl/key_channel.sv
// key_channel: one key - 2-flop synchroniser, debounce FSM, hold timing and registered event pulses
// Ports: clk, reset (sync, active-high), key_n (raw, 0 = pressed),
//        key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES - 1) + 1;
    localparam int HW = $clog2(LONG_PRESS_CYCLES + REPEAT_CYCLES) + 1;
    localparam bit REP_EN = REPEAT_CYCLES > 0;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LONG = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] H_REP = HW'(LONG_PRESS_CYCLES + REPEAT_CYCLES - 1);
    localparam logic [HW-1:0] H_RELOAD = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] H_MAX = HW'(LONG_PRESS_CYCLES + REPEAT_CYCLES);
    logic s1, s;
    logic [1:0] state;
    logic [DW-1:0] dcnt, dnext;
    logic [HW-1:0] hcnt;
    logic deb_done, rep_hit;
    assign dnext = dcnt + 1'b1;
    // >= keeps DEBOUNCE_CYCLES=1 from never completing
    assign deb_done = dnext >= D_LAST;
    assign rep_hit = REP_EN && hcnt == H_REP;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s <= 1'b1;
            state <= RELEASED;
            dcnt <= '0;
            hcnt <= '0;
            key_level <= 1'b0;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            s1 <= key_n;
            s <= s1;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                RELEASED: if (!s) begin
                    state <= PRESS_CHK;
                    dcnt <= '0;
                end
                PRESS_CHK: if (s) state <= RELEASED;
                else begin
                    dcnt <= dnext;
                    if (deb_done) begin
                        state <= PRESSED;
                        key_level <= 1'b1;
                        press_pulse <= 1'b1;
                        hcnt <= '0;
                    end
                end
                PRESSED: begin
                    // reloading to LONG_PRESS_CYCLES after each repeat gives the fixed repeat period
                    hcnt <= rep_hit ? H_RELOAD : (hcnt == H_MAX ? hcnt : hcnt + 1'b1);
                    long_pulse <= hcnt == H_LONG;
                    repeat_pulse <= rep_hit;
                    if (s) begin
                        state <= RELEASE_CHK;
                        dcnt <= '0;
                    end
                end
                RELEASE_CHK: if (!s) state <= PRESSED;
                else begin
                    dcnt <= dnext;
                    if (deb_done) begin
                        state <= RELEASED;
                        key_level <= 1'b0;
                        release_pulse <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: NUM_KEYS independent debounced key channels producing press/release/long/repeat events
// Ports: clk, reset (sync, active-high), bus (key_event_gen_if slave: key_n in, level and pulses out)
module key_event_gen
    import key_pkg::*;
#(
    parameter int NUM_KEYS          = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input logic clk,
    input logic reset,
    key_event_gen_if.slave bus
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .key_n(bus.key_n[i]),
            .key_level(bus.key_level[i]),
            .press_pulse(bus.press_pulse[i]),
            .release_pulse(bus.release_pulse[i]),
            .long_pulse(bus.long_pulse[i]),
            .repeat_pulse(bus.repeat_pulse[i])
        );
    end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed self-checking bench for key_event_gen (D=4, L=20, R=5 and an R=0 build)
module tb_key_event_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    key_event_gen_if #(.NUM_KEYS(3)) bus ();
    key_event_gen_if #(.NUM_KEYS(3)) bus0 ();
    key_event_gen #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    key_event_gen #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(0)) dut_norep (
        .clk(clk), .reset(reset), .bus(bus0));
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int n_press[3], n_rel[3], n_long[3], n_rep[3];
    int n_long0 = 0, n_rep0 = 0, clash = 0;
    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
        end
        n_long0 = 0;
        n_rep0 = 0;
    endtask
    // advance n edges; outputs are sampled 1 time unit after each edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                n_press[i] += int'(bus.press_pulse[i]);
                n_rel[i] += int'(bus.release_pulse[i]);
                n_long[i] += int'(bus.long_pulse[i]);
                n_rep[i] += int'(bus.repeat_pulse[i]);
            end
            n_long0 += int'(bus0.long_pulse[0]);
            n_rep0 += int'(bus0.repeat_pulse[0]);
            if ((bus.press_pulse & bus.release_pulse) != 3'b000 || (bus.long_pulse & bus.repeat_pulse) != 3'b000)
                clash++;
        end
    endtask
    function automatic int all_out();
        return int'({bus.key_level, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse});
    endfunction
    initial begin
        bus.key_n = 3'b111;
        bus0.key_n = 3'b111;
        clear_counts();
        reset = 1'b1;
        tick(3);
        check("reset outputs", all_out(), 0);
        reset = 1'b0;
        tick(2);
        check("idle outputs", all_out(), 0);
        // 1: clean press of key 0, held 10 cycles
        clear_counts();
        bus.key_n[0] = 1'b0;
        tick(5);
        check("t1 no early press", int'(bus.press_pulse), 0);
        tick(1);
        check("t1 press", int'(bus.press_pulse), 3'b001);
        check("t1 level", int'(bus.key_level), 3'b001);
        tick(1);
        check("t1 press one cycle", int'(bus.press_pulse), 0);
        tick(3);
        bus.key_n[0] = 1'b1;
        tick(5);
        check("t1 level held", int'(bus.key_level), 3'b001);
        check("t1 no early release", n_rel[0], 0);
        tick(1);
        check("t1 release", int'(bus.release_pulse), 3'b001);
        check("t1 level low", int'(bus.key_level), 0);
        tick(4);
        check("t1 press count", n_press[0], 1);
        check("t1 release count", n_rel[0], 1);
        check("t1 no long", n_long[0], 0);
        // 2: glitch then bounce on key 1
        clear_counts();
        bus.key_n[1] = 1'b0;
        tick(2);
        bus.key_n[1] = 1'b1;
        tick(10);
        check("t2 glitch no press", n_press[1], 0);
        check("t2 glitch level", int'(bus.key_level), 0);
        for (int i = 0; i < 8; i++) begin
            bus.key_n[1] = i[0];
            tick(1);
        end
        bus.key_n[1] = 1'b0;
        tick(5);
        check("t2 bounce no early press", n_press[1], 0);
        tick(1);
        check("t2 bounce press", int'(bus.press_pulse), 3'b010);
        tick(3);
        check("t2 single press", n_press[1], 1);
        bus.key_n[1] = 1'b1;
        tick(8);
        check("t2 release count", n_rel[1], 1);
        // 3: key 2 long hold with repeats
        clear_counts();
        bus.key_n[2] = 1'b0;
        tick(6);
        check("t3 press", int'(bus.press_pulse), 3'b100);
        tick(19);
        check("t3 no early long", n_long[2], 0);
        tick(1);
        check("t3 long", int'(bus.long_pulse), 3'b100);
        check("t3 no repeat with long", int'(bus.repeat_pulse), 0);
        tick(4);
        check("t3 no early repeat", n_rep[2], 0);
        tick(1);
        check("t3 first repeat", int'(bus.repeat_pulse), 3'b100);
        tick(14);
        bus.key_n[2] = 1'b1;
        tick(15);
        check("t3 long count", n_long[2], 1);
        check("t3 repeat count", n_rep[2], 4);
        check("t3 release count", n_rel[2], 1);
        check("t3 level low", int'(bus.key_level), 0);
        tick(10);
        check("t3 no repeat after release", n_rep[2], 4);
        // 4: keys 0 and 2 together
        clear_counts();
        bus.key_n = 3'b010;
        tick(6);
        check("t4 press both", int'(bus.press_pulse), 3'b101);
        check("t4 level both", int'(bus.key_level), 3'b101);
        bus.key_n = 3'b111;
        tick(8);
        check("t4 release both", n_rel[0] + n_rel[2], 2);
        // 5: reset mid-press
        clear_counts();
        bus.key_n[0] = 1'b0;
        tick(6);
        check("t5 press", int'(bus.press_pulse), 3'b001);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t5 reset outputs", all_out(), 0);
        reset = 1'b0;
        clear_counts();
        tick(5);
        check("t5 no early repress", n_press[0], 0);
        tick(1);
        check("t5 repress", int'(bus.press_pulse), 3'b001);
        tick(3);
        check("t5 no release", n_rel[0], 0);
        check("t5 level", int'(bus.key_level), 3'b001);
        bus.key_n[0] = 1'b1;
        tick(8);
        // 6: repeat-disabled build
        clear_counts();
        bus0.key_n[0] = 1'b0;
        tick(60);
        bus0.key_n[0] = 1'b1;
        tick(10);
        check("t6 long once", n_long0, 1);
        check("t6 no repeat", n_rep0, 0);
        check("t6 level low", int'(bus0.key_level), 0);
        check("no overlapping pulses", clash, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
